branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Sequential branch-resolution stage of the core; the producer side of the compare-result/func3 interface consumed by branch_decision.
- Captures operands, PC, immediate and predicted direction from the issue stage, and computes the comparator result and taken decision.
- On a misprediction, drives a redirect handshake to fetch, then asserts a pipeline flush for a fixed number of cycles.

Parameters:
XLEN, 32, operand/PC width
FLUSH_CYCLES, 2, cycles o_flush stays high after an accepted redirect (0 = no flush phase)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  issue presents a branch
o_ready  out  1  unit can accept (high only in IDLE)
i_rs1  in  XLEN  operand A
i_rs2  in  XLEN  operand B
i_func3  in  3  branch func3
i_pc  in  XLEN  branch PC
i_imm  in  XLEN  sign-extended B-immediate
i_pred_taken  in  1  fetch prediction
o_cmp_result  out  1  comparator result (feeds branch_decision i_result)
o_func3  out  3  registered func3 (feeds branch_decision i_func3)
o_taken  out  1  resolved direction
o_resolve_valid  out  1  one-cycle pulse: o_cmp_result/o_func3/o_taken valid
o_illegal  out  1  one-cycle pulse: func3 010/011
o_misalign  out  1  one-cycle pulse: taken target[1:0] != 0
o_redirect_valid  out  1  redirect request to fetch
o_redirect_pc  out  XLEN  correct next PC
i_redirect_ready  in  1  fetch accepts redirect
o_flush  out  1  squash younger instructions

Behaviour:
- Reset (async, i_rst_n low): state IDLE; every registered output 0, including o_redirect_pc; o_ready = 1 (decoded from IDLE). Inputs are ignored while reset is low. Reset mid-operation aborts any redirect or flush immediately, and no pulse is emitted.
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - Accept at an edge where i_valid & o_ready.
  - Capture rs1, rs2, func3, pc, imm and pred_taken.
  - Go to EVAL.
- EVAL (one cycle), compare rules:
  - func3[2]=0: cmp = (rs1 == rs2).
  - func3[2:1]=10: cmp = signed(rs1) < signed(rs2).
  - func3[2:1]=11: cmp = unsigned(rs1) < unsigned(rs2).
  - taken = cmp ^ func3[0].
- EVAL, illegal func3 (010/011): cmp = 0, taken = 0, o_illegal pulses, no redirect.
- EVAL, target and misprediction:
  - target = taken ? pc+imm : pc+4, computed modulo 2^XLEN with wrap-around silently allowed.
  - mispredict = taken != pred_taken.
- EVAL exit edge:
  - Register o_cmp_result, o_func3 and o_taken; these hold until the next EVAL.
  - o_resolve_valid = 1 for exactly one cycle.
  - Next state, first match wins:
    - illegal → IDLE;
    - taken & target[1:0] != 0 → o_misalign pulse, IDLE, no redirect;
    - mispredict → REDIRECT, with o_redirect_valid = 1 and o_redirect_pc = target;
    - otherwise → IDLE.
- Latency: accept at edge E0; resolve outputs visible E1→E2; redirect first visible E1→E2. Maximum throughput is one branch per 2 cycles.
- REDIRECT:
  - o_redirect_valid and o_redirect_pc held stable until an edge with i_redirect_ready = 1.
  - At that edge, o_redirect_valid drops. If FLUSH_CYCLES > 0, go to FLUSH with o_flush = 1 and the counter loaded with FLUSH_CYCLES-1; otherwise go to IDLE.
  - i_redirect_ready high in any other state is ignored.
- FLUSH:
  - o_flush is high for exactly FLUSH_CYCLES cycles.
  - The counter decrements each cycle; at 0, o_flush drops and the state returns to IDLE.
  - Counter width is clog2(FLUSH_CYCLES+1), minimum 1.
- o_ready = 1 only in IDLE; i_valid is ignored in all other states.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs o_branch_count[31:0] and o_mispredict_count[31:0], both reset to 0.
  - o_branch_count increments on every o_resolve_valid pulse, including illegal ones.
  - o_mispredict_count increments on every entry to REDIRECT.
  - Both counters wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - func3 localparams: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111;
  - state encoding (2-bit enum);
  - PC increment constant 4.
- Sub-module: branch_comparator, combinational; (rs1, rs2, func3) → cmp, illegal. Instantiated once in EVAL.

Test Plan:
- BEQ, rs1 = rs2 = 0x5, pc 0x100, imm 0x20, pred_taken 1 → o_cmp_result 1, o_taken 1, o_resolve_valid 1 cycle at E1, no redirect, o_ready high again at E1.
- BNE, rs1 = rs2 = 0x7, pc 0x200, pred_taken 1 → taken 0; o_redirect_valid with pc 0x204; i_redirect_ready held low 3 cycles, then high → redirect held stable, then o_flush high exactly 2 cycles, then IDLE.
- BLT, rs1 0xFFFFFFFF, rs2 0x1, pred 0 → taken 1, redirect to pc+imm. BLTU with the same operands → taken 0, no redirect.
- BGE, pc 0xFFFFFFF0, imm 0x20, pred 0 → target 0x00000010 (wrap), redirect issued. Taken target 0x102 → o_misalign pulse, no redirect.
- func3 010 → o_illegal pulse, o_taken 0, no redirect. i_valid held high continuously → accepts only in IDLE, one per 2 cycles.
- i_rst_n pulled low during REDIRECT and during FLUSH → immediately IDLE, all outputs 0, o_ready 1. With BRANCH_STATS_EN: 5 branches incl. 2 mispredicts → counts 5 / 2.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution stage: func3 codes, FSM state encoding
// and the sequential PC increment.
package branch_resolve_unit_pkg;

    localparam logic [2:0] Func3Beq  = 3'b000;
    localparam logic [2:0] Func3Bne  = 3'b001;
    localparam logic [2:0] Func3Blt  = 3'b100;
    localparam logic [2:0] Func3Bge  = 3'b101;
    localparam logic [2:0] Func3Bltu = 3'b110;
    localparam logic [2:0] Func3Bgeu = 3'b111;

    localparam int unsigned PcIncrement = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StEval     = 2'd1,
        StRedirect = 2'd2,
        StFlush    = 2'd3
    } state_e;

endpackage

// File: rtl/branch_resolve_unit_comparator.sv
// Combinational branch comparator: equality, signed and unsigned less-than selected by func3.
// Reserved func3 encodings (010/011) report illegal and force the compare result low.
module branch_resolve_unit_comparator
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      func3_i,
    output logic            cmp_o,
    output logic            illegal_o
);

    logic eq;
    logic lt_signed;
    logic lt_unsigned;

    assign eq          = (rs1_i == rs2_i);
    assign lt_signed   = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_unsigned = (rs1_i < rs2_i);

    always_comb begin
        cmp_o     = 1'b0;
        illegal_o = 1'b0;
        case (func3_i)
            Func3Beq, Func3Bne:   cmp_o = eq;
            Func3Blt, Func3Bge:   cmp_o = lt_signed;
            Func3Bltu, Func3Bgeu: cmp_o = lt_unsigned;
            default:              illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: captures an issued branch, resolves it one cycle later and, on a
// misprediction, runs a redirect handshake followed by a fixed-length flush.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_pred_taken,
    output logic            o_cmp_result,
    output logic [2:0]      o_func3,
    output logic            o_taken,
    output logic            o_resolve_valid,
    output logic            o_illegal,
    output logic            o_misalign,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    input  logic            i_redirect_ready,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count,
`endif
    output logic            o_flush
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_e          state_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            pred_q;
    logic [CntW-1:0] cnt_q;

    logic            cmp_result_q;
    logic [2:0]      func3_out_q;
    logic            taken_q;
    logic            resolve_valid_q;
    logic            illegal_q;
    logic            misalign_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;

    logic            cmp;
    logic            illegal;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            go_redirect;

    branch_resolve_unit_comparator #(
        .XLEN (XLEN)
    ) u_comparator (
        .rs1_i     (rs1_q),
        .rs2_i     (rs2_q),
        .func3_i   (func3_q),
        .cmp_o     (cmp),
        .illegal_o (illegal)
    );

    // Resolution decision from the captured branch; only consumed while in StEval.
    always_comb begin
        taken       = ~illegal & (cmp ^ func3_q[0]);
        target      = taken ? (pc_q + imm_q) : (pc_q + XLEN'(PcIncrement));
        misaligned  = ~illegal & taken & (target[1:0] != 2'b00);
        go_redirect = ~illegal & ~misaligned & (taken != pred_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= StIdle;
            rs1_q            <= '0;
            rs2_q            <= '0;
            func3_q          <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            pred_q           <= 1'b0;
            cnt_q            <= '0;
            cmp_result_q     <= 1'b0;
            func3_out_q      <= '0;
            taken_q          <= 1'b0;
            resolve_valid_q  <= 1'b0;
            illegal_q        <= 1'b0;
            misalign_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            resolve_valid_q <= 1'b0;
            illegal_q       <= 1'b0;
            misalign_q      <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        rs1_q   <= i_rs1;
                        rs2_q   <= i_rs2;
                        func3_q <= i_func3;
                        pc_q    <= i_pc;
                        imm_q   <= i_imm;
                        pred_q  <= i_pred_taken;
                        state_q <= StEval;
                    end
                end

                StEval: begin
                    cmp_result_q    <= cmp;
                    func3_out_q     <= func3_q;
                    taken_q         <= taken;
                    resolve_valid_q <= 1'b1;
                    if (illegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (misaligned) begin
                        misalign_q <= 1'b1;
                        state_q    <= StIdle;
                    end else if (go_redirect) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                        state_q          <= StRedirect;
                    end else begin
                        state_q <= StIdle;
                    end
                end

                StRedirect: begin
                    if (i_redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        if (FLUSH_CYCLES > 0) begin
                            flush_q <= 1'b1;
                            cnt_q   <= CntW'(FLUSH_CYCLES - 1);
                            state_q <= StFlush;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end

                StFlush: begin
                    if (cnt_q == '0) begin
                        flush_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (state_q == StEval) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (go_redirect) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign o_branch_count     = branch_count_q;
    assign o_mispredict_count = mispredict_count_q;
`endif

    assign o_ready          = (state_q == StIdle);
    assign o_cmp_result     = cmp_result_q;
    assign o_func3          = func3_out_q;
    assign o_taken          = taken_q;
    assign o_resolve_valid  = resolve_valid_q;
    assign o_illegal        = illegal_q;
    assign o_misalign       = misalign_q;
    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_flush          = flush_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue of expected resolutions.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  func3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred_taken;
    logic        cmp_result;
    logic [2:0]  func3_out;
    logic        taken;
    logic        resolve_valid;
    logic        illegal;
    logic        misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        cmp;
        logic [2:0]  f3;
        logic        tkn;
        logic        ill;
        logic        mis;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];

    branch_resolve_unit #(
        .XLEN         (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_valid            (valid),
        .o_ready            (ready),
        .i_rs1              (rs1),
        .i_rs2              (rs2),
        .i_func3            (func3),
        .i_pc               (pc),
        .i_imm              (imm),
        .i_pred_taken       (pred_taken),
        .o_cmp_result       (cmp_result),
        .o_func3            (func3_out),
        .o_taken            (taken),
        .o_resolve_valid    (resolve_valid),
        .o_illegal          (illegal),
        .o_misalign         (misalign),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc),
        .i_redirect_ready   (redirect_ready),
`ifdef BRANCH_STATS_EN
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count),
`endif
        .o_flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] p,
                                   input logic [31:0] im, input logic pr);
        exp_t        e;
        logic        c;
        logic [31:0] tgt;
        e = '0;
        c = 1'b0;
        e.ill = (f3 == 3'b010) || (f3 == 3'b011);
        if (f3[2] == 1'b0)       c = (a == b);
        else if (f3[1] == 1'b0)  c = ($signed(a) < $signed(b));
        else                     c = (a < b);
        if (e.ill) c = 1'b0;
        e.cmp   = c;
        e.f3    = f3;
        e.tkn   = e.ill ? 1'b0 : (c ^ f3[0]);
        tgt     = e.tkn ? (p + im) : (p + 32'd4);
        e.mis   = e.tkn && (tgt[1:0] != 2'b00);
        e.redir = !e.ill && !e.mis && (e.tkn != pr);
        e.rpc   = tgt;
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},    32'(ready), 32'd1);
        check({tag, "_outs"},     {26'd0, cmp_result, taken, resolve_valid, illegal, misalign,
                                   flush}, 32'd0);
        check({tag, "_func3"},    32'(func3_out), 32'd0);
        check({tag, "_rvalid"},   32'(redirect_valid), 32'd0);
        check({tag, "_rpc"},      redirect_pc, 32'd0);
`ifdef BRANCH_STATS_EN
        check({tag, "_bcount"},   branch_count, 32'd0);
        check({tag, "_mcount"},   mispredict_count, 32'd0);
`endif
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
        sb_q.push_back(model(f3, a, b, p, im, pr));
        @(negedge clk);
        valid = 1'b1; func3 = f3; rs1 = a; rs2 = b; pc = p; imm = im; pred_taken = pr;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Waits for the resolve pulse, compares against the oldest expectation, then checks
    // that the pulse lasts one cycle. Ends just after a falling edge.
    task automatic resolve(input string tag, output logic redir, output logic [31:0] rpc);
        exp_t e;
        int   waited;
        waited = 0;
        redir  = 1'b0;
        rpc    = '0;
        @(negedge clk);
        while (!resolve_valid && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_resolve_seen"}, 32'(resolve_valid), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            redir = e.redir;
            rpc   = e.rpc;
            check({tag, "_cmp"},      32'(cmp_result), 32'(e.cmp));
            check({tag, "_func3"},    32'(func3_out), 32'(e.f3));
            check({tag, "_taken"},    32'(taken), 32'(e.tkn));
            check({tag, "_illegal"},  32'(illegal), 32'(e.ill));
            check({tag, "_misalign"}, 32'(misalign), 32'(e.mis));
            check({tag, "_rvalid"},   32'(redirect_valid), 32'(e.redir));
            check({tag, "_ready"},    32'(ready), 32'(!e.redir));
            if (e.redir) check({tag, "_rpc"}, redirect_pc, e.rpc);
        end
        @(negedge clk);
        check({tag, "_pulse_end"}, {29'd0, resolve_valid, illegal, misalign}, 32'd0);
    endtask

    task automatic finish_redirect(input string tag, input int delay, input logic [31:0] rpc);
        int nflush;
        for (int k = 0; k < delay; k++) begin
            check({tag, "_hold_valid"}, 32'(redirect_valid), 32'd1);
            check({tag, "_hold_pc"},    redirect_pc, rpc);
            check({tag, "_hold_noflush"}, 32'(flush), 32'd0);
            @(negedge clk);
        end
        redirect_ready = 1'b1;
        @(posedge clk);
        #1 redirect_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid_drop"}, 32'(redirect_valid), 32'd0);
        nflush = 0;
        while (flush && nflush < 10) begin
            nflush++;
            @(negedge clk);
        end
        check({tag, "_flush_cycles"}, nflush, 32'd2);
        check({tag, "_idle_ready"},   32'(ready), 32'd1);
    endtask

    logic        r_redir;
    logic [31:0] r_pc;
    int          n_pulses;

    initial begin
        rst_n = 1'b0; valid = 1'b0; rs1 = '0; rs2 = '0; func3 = '0; pc = '0; imm = '0;
        pred_taken = 1'b0; redirect_ready = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correctly predicted taken BEQ
        issue(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1);
        resolve("beq", r_redir, r_pc);

        // BNE not taken against a taken prediction: held redirect then flush
        issue(3'b001, 32'h7, 32'h7, 32'h200, 32'h40, 1'b1);
        resolve("bne", r_redir, r_pc);
        check("bne_redirect_pc_exp", r_pc, 32'h204);
        finish_redirect("bne", 2, r_pc);

        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h80, 1'b0);
        resolve("blt", r_redir, r_pc);
        if (r_redir) finish_redirect("blt", 0, r_pc);

        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h80, 1'b0);
        resolve("bltu", r_redir, r_pc);

        // Target wraps past 2^32
        issue(3'b101, 32'h5, 32'h3, 32'hFFFF_FFF0, 32'h20, 1'b0);
        resolve("bge_wrap", r_redir, r_pc);
        if (r_redir) finish_redirect("bge_wrap", 1, r_pc);

        issue(3'b000, 32'h9, 32'h9, 32'h100, 32'h2, 1'b0);
        resolve("misalign", r_redir, r_pc);

        issue(3'b010, 32'h1, 32'h1, 32'h500, 32'h10, 1'b1);
        resolve("illegal", r_redir, r_pc);

        // i_valid held high: accepts only from IDLE, one every two cycles
        @(negedge clk);
        valid = 1'b1; func3 = 3'b000; rs1 = 32'h1; rs2 = 32'h1; pc = 32'h400; imm = 32'h8;
        pred_taken = 1'b1;
        n_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resolve_valid) n_pulses++;
            check("stream_ready", 32'(ready), 32'(i % 2));
        end
        valid = 1'b0;
        check("stream_pulses", n_pulses, 32'd4);

        // Reset while a redirect is pending
        issue(3'b001, 32'h7, 32'h7, 32'h600, 32'h40, 1'b1);
        resolve("rst_redir", r_redir, r_pc);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_in_redirect");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the flush phase
        issue(3'b001, 32'h7, 32'h7, 32'h700, 32'h40, 1'b1);
        resolve("rst_flush", r_redir, r_pc);
        redirect_ready = 1'b1;
        @(posedge clk);
        #1 redirect_ready = 1'b0;
        @(negedge clk);
        check("rst_flush_active", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_in_flush");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
        issue(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1);
        resolve("st1", r_redir, r_pc);
        issue(3'b001, 32'h7, 32'h7, 32'h200, 32'h40, 1'b1);
        resolve("st2", r_redir, r_pc);
        if (r_redir) finish_redirect("st2", 0, r_pc);
        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h80, 1'b0);
        resolve("st3", r_redir, r_pc);
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h80, 1'b0);
        resolve("st4", r_redir, r_pc);
        if (r_redir) finish_redirect("st4", 0, r_pc);
        issue(3'b011, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1);
        resolve("st5", r_redir, r_pc);
        check("stats_branches",    branch_count, 32'd5);
        check("stats_mispredicts", mispredict_count, 32'd2);
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
